// File: rtl/reg_file_wb_pkg.sv
// Shared constants and types for the write-back register bank.
// Imported by the stage register and the bank top.
package reg_file_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/wb_stage.sv
// Write-back pipeline register: holds one pending write.
// Writes to r0 never enter the stage.
module wb_stage
    import reg_file_wb_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      we,
    input  reg_addr_t wa,
    input  reg_data_t di,
    output logic      wb_valid,
    output reg_addr_t wb_addr,
    output reg_data_t wb_data
);

    logic cap;

    assign cap = we && (wa != REG_ZERO);

    // Capture a valid write; park addr/data at 0 otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= cap;
            wb_addr  <= cap ? wa : REG_ZERO;
            wb_data  <= cap ? di : '0;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// 32-entry register bank with a registered write-back stage.
// Reads forward the pending stage value; r0 reads as zero.
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      we,
    input  reg_addr_t wa,
    input  reg_data_t di,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    output reg_data_t do1,
    output reg_data_t do2,
    output logic      wb_pend,
    output reg_addr_t wb_addr
);

    logic      wb_valid;
    reg_addr_t stg_addr;
    reg_data_t stg_data;

    // r0 has no storage
    reg_data_t regs [1:NREG-1];

    wb_stage u_wb_stage (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wa       (wa),
        .di       (di),
        .wb_valid (wb_valid),
        .wb_addr  (stg_addr),
        .wb_data  (stg_data)
    );

    // Commit the staged write one edge after capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[stg_addr] <= stg_data;
        end
    end

    // Read muxes: zero, then stage bypass, then array
    always_comb begin
        do1 = '0;
        do2 = '0;
        if (ra1 != REG_ZERO) begin
            do1 = (wb_valid && ra1 == stg_addr) ? stg_data : regs[ra1];
        end
        if (ra2 != REG_ZERO) begin
            do2 = (wb_valid && ra2 == stg_addr) ? stg_data : regs[ra2];
        end
    end

    assign wb_pend = wb_valid;
    assign wb_addr = wb_valid ? stg_addr : REG_ZERO;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb.
// Reference: architectural registers where a write becomes visible next cycle.
module tb_reg_file_wb;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] di;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] do1;
    logic [31:0] do2;
    logic        wb_pend;
    logic [4:0]  wb_addr;

    reg_file_wb dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wa      (wa),
        .di      (di),
        .ra1     (ra1),
        .ra2     (ra2),
        .do1     (do1),
        .do2     (do2),
        .wb_pend (wb_pend),
        .wb_addr (wb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        pend;
        logic [4:0]  addr;
    } exp_t;

    exp_t exp_q [$];

    int n_cmp  = 0;
    int n_fail = 0;
    bit stim_done = 0;

    // Reference model state
    logic [31:0] arch [0:31];
    bit          last_wr;
    logic [4:0]  last_wa;

    task automatic chk(input string nm, input string tag,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, nm, act, req);
        end
    endtask

    // One clock cycle of stimulus; expectation computed from model
    task automatic step(input string tag, input bit r, input bit w,
                        input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        @(negedge clk);
        reset = r;
        we    = w;
        wa    = a;
        di    = d;
        ra1   = r1;
        ra2   = r2;
        e.tag = tag;
        if (r) begin
            e.d1   = 32'h0;
            e.d2   = 32'h0;
            e.pend = 1'b0;
            e.addr = 5'd0;
        end else begin
            e.d1   = (r1 == 0) ? 32'h0 : arch[r1];
            e.d2   = (r2 == 0) ? 32'h0 : arch[r2];
            e.pend = last_wr;
            e.addr = last_wr ? last_wa : 5'd0;
        end
        exp_q.push_back(e);
        if (r) begin
            for (int i = 0; i < 32; i++) arch[i] = 32'h0;
            last_wr = 0;
            last_wa = 0;
        end else begin
            last_wr = w && (a != 0);
            last_wa = a;
            if (last_wr) arch[a] = d;
        end
    endtask

    // Monitor: samples mid-cycle, after stimulus has settled
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("do1", e.tag, do1, e.d1);
                chk("do2", e.tag, do2, e.d2);
                chk("wb_pend", e.tag, {31'h0, wb_pend}, {31'h0, e.pend});
                chk("wb_addr", e.tag, {27'h0, wb_addr}, {27'h0, e.addr});
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        we = 0; wa = 0; di = 0; ra1 = 0; ra2 = 0;
        for (int i = 0; i < 32; i++) arch[i] = 32'h0;
        last_wr = 0;
        last_wa = 0;

        step("rst", 1, 0, 0, 0, 0, 0);
        step("rst", 1, 1, 4, 32'h55, 4, 4);

        // r5 write timeline
        step("r5_c0", 0, 1, 5, 32'hDEADBEEF, 5, 0);
        step("r5_c1", 0, 0, 0, 0, 5, 5);
        step("r5_c2", 0, 0, 0, 0, 5, 1);
        step("r5_c3", 0, 0, 0, 0, 2, 5);

        // r0 write dropped
        step("r0_w", 0, 1, 0, 32'h12345678, 0, 0);
        step("r0_r", 0, 0, 0, 0, 0, 0);
        step("r0_r", 0, 0, 0, 0, 0, 0);

        // back-to-back r7
        step("r7_c0", 0, 1, 7, 32'h1, 0, 7);
        step("r7_c1", 0, 1, 7, 32'h2, 0, 7);
        step("r7_c2", 0, 0, 0, 0, 7, 7);
        step("r7_c3", 0, 0, 0, 0, 7, 7);

        // pending write discarded by reset
        step("r3_w", 0, 1, 3, 32'hA, 3, 3);
        step("r3_rst", 1, 0, 0, 0, 3, 5);
        step("r3_after", 0, 0, 0, 0, 3, 5);
        step("r3_after", 0, 0, 0, 0, 3, 7);

        // fill and sweep
        for (int i = 1; i < 32; i++)
            step("fill", 0, 1, 5'(i), 32'(i), 5'(i), 5'(i - 1));
        for (int i = 0; i < 32; i++)
            step("sweep", 0, 0, 0, 0, 5'(i), 5'(i));
        for (int i = 0; i < 32; i++)
            step("sweep2", 0, 0, 0, 0, 5'(i), 5'(31 - i));

        // reset with populated array, every address
        for (int i = 0; i < 32; i++)
            step("rst_sweep", 1, 0, 0, 0, 5'(i), 5'(31 - i));

        // randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 7));
            step("rand", ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) != 0), a, $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        step("tail", 0, 0, 0, 0, 1, 2);

        stim_done = 1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        #5;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
